// File: rtl/timeslice_arbiter.sv
// Time-sliced round-robin arbiter: registered one-hot grant, capped at SLICE_TIME cycles, one-cycle gap between owners.
// Optional TSARB_LOCK_EN adds a `lock` input that holds the grant past slice expiry while asserted.
module timeslice_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int SLICE_TIME = 20,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
`ifdef TSARB_LOCK_EN
    input  logic               lock,
`endif
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [ID_W-1:0]    gnt_id,
    output logic               slice_expired
);

    localparam int CNT_W = $clog2(SLICE_TIME + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    ptr_nxt;
    logic [ID_W-1:0]    ptr_after;
    logic [ID_W-1:0]    gnt_id_nxt;
    logic [ID_W-1:0]    pick_id;
    logic [ID_W-1:0]    idx;
    logic               pick_vld;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic               slice_expired_nxt;
    logic               lock_on;

`ifdef TSARB_LOCK_EN
    assign lock_on = lock;
`else
    assign lock_on = 1'b0;
`endif

    // First requester at or after ptr, wrapping round.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!pick_vld && req[idx]) begin
                pick_vld = 1'b1;
                pick_id  = idx;
            end
        end
    end

    // gnt_id always holds the owner while in GRANT.
    assign ptr_after = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

    always_comb begin
        state_nxt         = state;
        ptr_nxt           = ptr;
        cnt_nxt           = cnt;
        gnt_nxt           = gnt;
        gnt_id_nxt        = gnt_id;
        slice_expired_nxt = 1'b0;
        case (state)
            IDLE, GAP: begin
                if (pick_vld) begin
                    state_nxt          = GRANT;
                    gnt_nxt            = '0;
                    gnt_nxt[pick_id]   = 1'b1;
                    gnt_id_nxt         = pick_id;
                    cnt_nxt            = CNT_W'(1);
                end else begin
                    state_nxt  = IDLE;
                    gnt_nxt    = '0;
                    gnt_id_nxt = '0;
                    cnt_nxt    = '0;
                end
            end
            GRANT: begin
                if (!req[gnt_id]) begin
                    state_nxt  = GAP;
                    ptr_nxt    = ptr_after;
                    gnt_nxt    = '0;
                    gnt_id_nxt = '0;
                    cnt_nxt    = '0;
                end else if (cnt < CNT_W'(SLICE_TIME)) begin
                    cnt_nxt = cnt + 1'b1;
                end else if (!lock_on) begin
                    state_nxt         = GAP;
                    ptr_nxt           = ptr_after;
                    gnt_nxt           = '0;
                    gnt_id_nxt        = '0;
                    cnt_nxt           = '0;
                    slice_expired_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt  = IDLE;
                gnt_nxt    = '0;
                gnt_id_nxt = '0;
                cnt_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            cnt           <= '0;
            gnt           <= '0;
            gnt_valid     <= 1'b0;
            gnt_id        <= '0;
            slice_expired <= 1'b0;
        end else begin
            state         <= state_nxt;
            ptr           <= ptr_nxt;
            cnt           <= cnt_nxt;
            gnt           <= gnt_nxt;
            gnt_valid     <= |gnt_nxt;
            gnt_id        <= gnt_id_nxt;
            slice_expired <= slice_expired_nxt;
        end
    end

endmodule
